// File: rtl/mult4_rr_sequencer.sv
// Round-robin front-end that time-shares one external 4x4 unsigned multiplier
// between NREQ requesters and returns each product with its owner's ID.
module mult4_rr_sequencer #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_x,
  input  logic [4*NREQ-1:0] req_y,
  output logic [3:0]        mul_x,
  output logic [3:0]        mul_y,
  input  logic [7:0]        mul_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_p
);

  typedef enum logic [1:0] {IDLE, MUL, RSP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] grant_inc;
  logic [IDW-1:0] id_p1;
  logic [NREQ-1:0] rot;
  logic           found;
  logic           accept;
  logic [3:0]     sel_x, sel_y;

  function automatic logic [IDW-1:0] wrap_idx(input int s);
    return (s >= NREQ) ? IDW'(s - NREQ) : IDW'(s);
  endfunction

  // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
  always_comb begin
    rot   = NREQ'({req_valid, req_valid} >> ptr);
    found = 1'b0;
    grant = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        grant = wrap_idx(int'(ptr) + k);
      end
    end
  end

  assign grant_inc = (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
  assign accept    = (state == IDLE) && found;
  assign req_ready = accept ? (NREQ'(1) << grant) : '0;
  assign sel_x     = 4'(req_x >> {grant, 2'b00});
  assign sel_y     = 4'(req_y >> {grant, 2'b00});
  assign rsp_valid = (state == RSP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)     state_nxt = MUL;
      MUL:                    state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Stage 1: latch the winner's operands; they drive the multiplier during MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      mul_x <= '0;
      mul_y <= '0;
      id_p1 <= '0;
    end else if (accept) begin
      ptr   <= grant_inc;
      mul_x <= sel_x;
      mul_y <= sel_y;
      id_p1 <= grant;
    end
  end

  // Stage 2: capture the product at the end of MUL and hold it through RSP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_p  <= '0;
      rsp_id <= '0;
    end else if (state == MUL) begin
      rsp_p  <= mul_p;
      rsp_id <= id_p1;
    end
  end

endmodule

// File: tb/tb_mult4_rr_sequencer.sv
// Bench for mult4_rr_sequencer: table of single requests, arbitration and
// corner-case sequences, responses matched against a scoreboard queue.
module tb_mult4_rr_sequencer;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_x;
  logic [4*NREQ-1:0] req_y;
  logic [3:0]        mul_x, mul_y;
  logic [7:0]        mul_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_p;

  mult4_rr_sequencer #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p)
  );

  always #5 clk = ~clk;

  // The shared combinational multiplier lives outside the sequencer.
  assign mul_p = {4'b0, mul_x} * {4'b0, mul_y};

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     p;
  } exp_t;

  typedef struct {
    int         r;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] p;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Completed responses are popped from the scoreboard on the handshake cycle.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      chk("rsp_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_p", 32'(rsp_p), 32'(mon_e.p));
      end
    end
  end

  task automatic set_req(input int r, input logic [3:0] x, input logic [3:0] y);
    req_x[4*r +: 4] = x;
    req_y[4*r +: 4] = y;
  endtask

  task automatic push_exp(input int g, input logic [7:0] p);
    exp_t e;
    e.id = IDW'(g);
    e.p  = p;
    sbq.push_back(e);
  endtask

  // Called so that the next negedge is the IDLE cycle where g must win.
  task automatic grant_seq(input int g, input logic [3:0] x, input logic [3:0] y,
                           input logic [7:0] p, input bit drop);
    @(negedge clk);
    chk("req_ready_grant", 32'(req_ready), 32'(1) << g);
    push_exp(g, p);
    @(posedge clk); #1;
    if (drop) req_valid[g] = 1'b0;
    @(negedge clk);
    chk("mul_x", 32'(mul_x), 32'(x));
    chk("mul_y", 32'(mul_y), 32'(y));
    chk("req_ready_mul", 32'(req_ready), 32'd0);
    chk("rsp_valid_mul", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rsp_valid_rsp", 32'(rsp_valid), 32'd1);
    chk("req_ready_rsp", 32'(req_ready), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{r: 2, x: 4'd15, y: 4'd15, p: 8'd225};
    tbl[1] = '{r: 2, x: 4'd0,  y: 4'd9,  p: 8'd0};
    tbl[2] = '{r: 0, x: 4'd1,  y: 4'd1,  p: 8'd1};
    tbl[3] = '{r: 3, x: 4'd15, y: 4'd0,  p: 8'd0};
    tbl[4] = '{r: 1, x: 4'd8,  y: 4'd8,  p: 8'd64};
    tbl[5] = '{r: 3, x: 4'd12, y: 4'd10, p: 8'd120};

    rst = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_p", 32'(rsp_p), 32'd0);
    chk("reset_mul_x", 32'(mul_x), 32'd0);
    chk("reset_mul_y", 32'(mul_y), 32'd0);

    // Single requests, one at a time, straight from the table.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_req(tbl[i].r, tbl[i].x, tbl[i].y);
      req_valid[tbl[i].r] = 1'b1;
      grant_seq(tbl[i].r, tbl[i].x, tbl[i].y, tbl[i].p, 1'b1);
    end
    drain();

    // All four valid at once: pointer order 0..3, three cycles apart.
    do_reset();
    set_req(0, 4'd3, 4'd5);
    set_req(1, 4'd7, 4'd2);
    set_req(2, 4'd9, 4'd9);
    set_req(3, 4'd15, 4'd1);
    req_valid = 4'hF;
    grant_seq(0, 4'd3, 4'd5, 8'd15, 1'b1);
    grant_seq(1, 4'd7, 4'd2, 8'd14, 1'b1);
    grant_seq(2, 4'd9, 4'd9, 8'd81, 1'b1);
    grant_seq(3, 4'd15, 4'd1, 8'd15, 1'b1);
    drain();

    // Requesters 0 and 3 held valid: alternate, grant to 3 wraps ptr to 0.
    do_reset();
    set_req(0, 4'd2, 4'd3);
    set_req(3, 4'd4, 4'd5);
    req_valid = 4'b1001;
    grant_seq(0, 4'd2, 4'd3, 8'd6, 1'b0);
    grant_seq(3, 4'd4, 4'd5, 8'd20, 1'b0);
    grant_seq(0, 4'd2, 4'd3, 8'd6, 1'b0);
    grant_seq(3, 4'd4, 4'd5, 8'd20, 1'b1);
    req_valid = '0;
    drain();

    // Back-pressure: response held through five stalled cycles.
    do_reset();
    rsp_ready = 1'b0;
    set_req(1, 4'd11, 4'd13);
    set_req(0, 4'd5, 4'd6);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'b0010);
    push_exp(1, 8'd143);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("bp_ready_mul", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_p", 32'(rsp_p), 32'd143);
      chk("bp_rsp_id", 32'(rsp_id), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_valid_hs", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_idle_grant", 32'(req_ready), 32'b0001);
    push_exp(0, 8'd30);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Reset during MUL discards the transaction.
    do_reset();
    set_req(0, 4'd6, 4'd7);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("mr_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_mul_x", 32'(mul_x), 32'd6);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_mul_x_rst", 32'(mul_x), 32'd0);
    chk("mr_mul_y_rst", 32'(mul_y), 32'd0);
    chk("mr_rsp_p", 32'(rsp_p), 32'd0);
    chk("mr_rsp_id", 32'(rsp_id), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 4'b0001;
    grant_seq(0, 4'd6, 4'd7, 8'd42, 1'b1);
    drain();

    // Every operand pair through requester 1.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        @(posedge clk); #1;
        set_req(1, 4'(x), 4'(y));
        req_valid = 4'b0010;
        grant_seq(1, 4'(x), 4'(y), 8'(x * y), 1'b1);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult4_rr_sequencer.md
# mult4_rr_sequencer

Sequential front-end that shares one combinational 4x4 unsigned array multiplier (8-bit product) between NREQ requesters. It arbitrates requests round-robin and registers the operands of the winner. It drives the shared multiplier for exactly one cycle, captures the product, and returns it with the requester ID over a valid/ready response channel. It sits between the multiplier clients and the single multiplier instance, so that only one copy of the partial-product tree and adder is built.

## Interface
Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, response ID width; equals clog2(NREQ) and is set consistently by the instantiator.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request i valid.
- req_ready  out  NREQ  request i accepted this cycle; at most one bit is high.
- req_x  in  4*NREQ  operand x of requester i, in bits [4i+3:4i].
- req_y  in  4*NREQ  operand y of requester i, in bits [4i+3:4i].
- mul_x  out  4  x operand to the shared multiplier; registered.
- mul_y  out  4  y operand to the shared multiplier; registered.
- mul_p  in  8  product from the shared multiplier; combinational from mul_x/mul_y.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that owns rsp_p.
- rsp_p  out  8  unsigned product x*y, range 0..225.

## Operation
- FSM states: IDLE, MUL, RSP. Reset state is IDLE.
- IDLE:
  - The arbiter scans req_valid starting at ptr, then ptr+1, and so on, wrapping modulo NREQ. The first set bit g wins.
  - req_ready[g] = 1 combinationally, only while in IDLE. All other req_ready bits are 0.
  - When req_valid[g] & req_ready[g] on an edge: op_x <= req_x[g], op_y <= req_y[g], id <= g, ptr <= (g+1) mod NREQ, state <= MUL.
  - If no request is valid, stay in IDLE and leave ptr unchanged.
- MUL:
  - mul_x/mul_y hold op_x/op_y for the whole cycle.
  - At the end of the cycle: rsp_p <= mul_p, rsp_id <= id, state <= RSP.
- RSP:
  - rsp_valid = 1. rsp_p and rsp_id are held stable.
  - On rsp_valid & rsp_ready: state <= IDLE.
  - Without rsp_ready, stay in RSP indefinitely.
- Requesters hold req_valid and operands stable until accepted. Any request not granted in a cycle is retried automatically in later arbitration.
- Arithmetic: 4-bit unsigned operands, full 8-bit product, no truncation or overflow.
- mul_x/mul_y keep their last value outside MUL; they are reset to 0.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0 except as granted combinationally in IDLE, mul_x=0, mul_y=0, rsp_valid=0, rsp_id=0, rsp_p=0.
- Cycle-level latency:
  - Request accepted in cycle T.
  - MUL in cycle T+1.
  - rsp_valid first high in cycle T+2.
- Throughput: with rsp_ready tied high, one request completes every 3 cycles; the next acceptance is in cycle T+3.
- No new acceptance while in MUL or RSP: req_ready is all 0.
- Simultaneous requests: exactly one is granted, chosen by the rotating pointer. A continuously asserted requester waits at most NREQ-1 other grants.
- Pointer wrap: a grant to NREQ-1 sets ptr=0.
- Reset mid-operation (rst high in MUL or RSP): the in-flight transaction is discarded with no response, and all outputs go to their reset values on that edge.
- rst has priority over every handshake in the same cycle.

## Test plan
- Single request, zero operand: after reset, requester 2 sends x=15, y=15 -> req_ready[2] in cycle T; rsp_valid in cycle T+2 with rsp_id=2, rsp_p=225. Then x=0, y=9 -> rsp_p=0.
- Simultaneous requests: all four valid from reset with (x,y) = (3,5), (7,2), (9,9), (15,1) -> responses in order id 0,1,2,3 with products 15, 14, 81, 15, each 3 cycles apart when rsp_ready=1.
- Fairness and wrap: requesters 3 and 0 always valid, ptr starts at 0 -> grant order 0,3,0,3. The grant to 3 sets ptr to 0.
- Back-pressure: rsp_ready=0 for 5 cycles during RSP -> rsp_valid stays high, rsp_p/rsp_id stay stable, req_ready stays 0. After rsp_ready rises, the FSM returns to IDLE the next cycle.
- Reset mid-operation: assert rst in the MUL cycle of (x=6, y=7) -> no response; all outputs at reset values the next cycle. The next request after reset completes normally (e.g. 6*7=42).
- Exhaustive arithmetic: all 256 (x,y) pairs through requester 1, checked against x*y.
